roc_stream_encoder: RTL and testbench

- Parametrised rank-order-coding (ROC) encoder. Accepts a streamed image, counting-sorts the pixel indices by intensity, then emits the sorted indices one at a time over the 10-bit-style AER input link.
- Sits between the image source and the AER input controller of the SNN core.
- Additions: configurable depth and widths, a brightest-first or darkest-first mode, an intensity cut-off threshold, a spike cap, and an abort.

---
 rtl/roc_pkg.sv | 21 ++
 rtl/roc_histogram.sv | 54 +++++
 rtl/roc_stream_encoder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_roc_stream_encoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/roc_pkg.sv
// Shared types and defaults for the rank-order-coding stream encoder.
package roc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CUMSUM,
    SORT,
    PREFIX,
    EMIT,
    WAIT_AER
  } roc_state_t;

  typedef enum logic {
    ROC_BRIGHT_FIRST = 1'b0,
    ROC_DARK_FIRST   = 1'b1
  } roc_mode_t;

  localparam logic [31:0] ROC_RESET_CODE_DEFAULT = 32'h0000_01FF;

endpackage

// File: rtl/roc_histogram.sv
// Intensity histogram bin memory: clear, increment, running-sum accumulate
// in either direction, and decrement, all addressed through one bin port.
module roc_histogram
  import roc_pkg::*;
#(
  parameter int IMAGE_SIZE = 256,
  parameter int PIXEL_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        inc_en,
  input  logic                        acc_en,
  input  logic                        acc_dark,
  input  logic                        dec_en,
  input  logic [PIXEL_BITS-1:0]       bin,
  output logic [$clog2(IMAGE_SIZE):0] rd_cnt
);

  localparam int CW = $clog2(IMAGE_SIZE) + 1;
  localparam int NB = 2 ** PIXEL_BITS;
  localparam logic [CW-1:0]         ONE_CNT = 1;
  localparam logic [PIXEL_BITS-1:0] ONE_BIN = 1;

  logic [CW-1:0]         bins_q [NB];
  logic [CW-1:0]         bins_d [NB];
  logic [PIXEL_BITS-1:0] src_bin;

  // Accumulation pulls from the neighbour already visited by the sweep.
  assign src_bin = acc_dark ? (bin - ONE_BIN) : (bin + ONE_BIN);
  assign rd_cnt  = bins_q[bin];

  always_comb begin
    bins_d = bins_q;
    if (clr) begin
      for (int b = 0; b < NB; b++) bins_d[b] = '0;
    end else if (inc_en) begin
      bins_d[bin] = bins_q[bin] + ONE_CNT;
    end else if (acc_en) begin
      bins_d[bin] = bins_q[bin] + bins_q[src_bin];
    end else if (dec_en) begin
      bins_d[bin] = bins_q[bin] - ONE_CNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) bins_q[b] <= '0;
    end else begin
      bins_q <= bins_d;
    end
  end

endmodule

// File: rtl/roc_stream_encoder.sv
// Rank-order-coding encoder: loads a frame, counting-sorts pixel indices by
// intensity and streams them (after optional reset words) over the AER link.
module roc_stream_encoder
  import roc_pkg::*;
#(
  parameter int          IMAGE_SIZE  = 256,
  parameter int          PIXEL_BITS  = 8,
  parameter int          AER_BITS    = 10,
  parameter int          RESET_WORDS = 2,
  parameter logic [31:0] RESET_CODE  = ROC_RESET_CODE_DEFAULT
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        NEW_IMAGE,
  input  logic                        MODE,
  input  logic [PIXEL_BITS-1:0]       THRESH,
  input  logic [$clog2(IMAGE_SIZE):0] MAX_SPIKES,
  input  logic                        PIX_VALID,
  input  logic [PIXEL_BITS-1:0]       PIX_DATA,
  output logic                        PIX_READY,
  input  logic                        AERIN_CTRL_BUSY,
  input  logic                        INFERENCE_RDY,
  output logic [AER_BITS-1:0]         NEXT_INDEX,
  output logic                        FOUND_NEXT_INDEX,
  output logic [$clog2(IMAGE_SIZE):0] SPIKE_COUNT,
  output logic                        FRAME_DONE,
  output logic                        ENCODER_RDY
);

  localparam int IW = $clog2(IMAGE_SIZE);
  localparam int CW = IW + 1;
  localparam int WW = (RESET_WORDS > 0) ? $clog2(RESET_WORDS + 1) : 1;

  localparam logic [IW-1:0]         LAST_PIX   = IW'(IMAGE_SIZE - 1);
  localparam logic [IW-1:0]         ONE_IDX    = 1;
  localparam logic [CW-1:0]         FULL_CNT   = CW'(IMAGE_SIZE);
  localparam logic [CW-1:0]         ONE_CNT    = 1;
  localparam logic [PIXEL_BITS-1:0] MAX_BIN    = '1;
  localparam logic [PIXEL_BITS-1:0] ONE_BIN    = 1;
  localparam logic [WW-1:0]         PREFIX_LEN = WW'(RESET_WORDS);
  localparam logic [WW-1:0]         ONE_WORD   = 1;
  localparam logic [AER_BITS-1:0]   RESET_WORD = AER_BITS'(RESET_CODE);

  roc_state_t            state_q, state_d;
  roc_mode_t             mode_q, mode_d;
  logic [PIXEL_BITS-1:0] thresh_q, thresh_d;
  logic [CW-1:0]         max_q, max_d;
  logic [IW-1:0]         pix_cnt_q, pix_cnt_d;
  logic [PIXEL_BITS-1:0] bin_q, bin_d;
  logic [IW-1:0]         sort_i_q, sort_i_d;
  logic [WW-1:0]         word_cnt_q, word_cnt_d;
  logic [CW-1:0]         spike_cnt_q, spike_cnt_d;
  logic                  abort_pend_q, abort_pend_d;
  logic [AER_BITS-1:0]   next_index_q, next_index_d;
  logic                  pix_ready_q, pix_ready_d;
  logic                  frame_done_q, frame_done_d;
  logic                  enc_rdy_q, enc_rdy_d;

  logic [PIXEL_BITS-1:0] img_q    [IMAGE_SIZE];
  logic [PIXEL_BITS-1:0] img_d    [IMAGE_SIZE];
  logic [IW-1:0]         sorted_q [IMAGE_SIZE];
  logic [IW-1:0]         sorted_d [IMAGE_SIZE];

  logic                  h_clr, h_inc, h_acc, h_dec;
  logic [PIXEL_BITS-1:0] h_bin;
  logic [CW-1:0]         h_cnt;

  logic [PIXEL_BITS-1:0] sort_pix;
  logic [IW-1:0]         sort_pos;
  logic [IW-1:0]         emit_idx;
  logic [PIXEL_BITS-1:0] emit_pix;
  logic                  emit_end;
  logic                  found;
  logic [AER_BITS-1:0]   word;
  logic                  dark;

  roc_histogram #(
    .IMAGE_SIZE (IMAGE_SIZE),
    .PIXEL_BITS (PIXEL_BITS)
  ) u_hist (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr      (h_clr),
    .inc_en   (h_inc),
    .acc_en   (h_acc),
    .acc_dark (dark),
    .dec_en   (h_dec),
    .bin      (h_bin),
    .rd_cnt   (h_cnt)
  );

  assign dark     = (mode_q == ROC_DARK_FIRST);
  assign sort_pix = img_q[sort_i_q];
  assign sort_pos = IW'(h_cnt - ONE_CNT);
  assign emit_idx = sorted_q[spike_cnt_q[IW-1:0]];
  assign emit_pix = img_q[emit_idx];

  // Sorted order means the first pixel failing the cut-off ends the frame.
  assign emit_end = (spike_cnt_q == FULL_CNT) ||
                    ((max_q != '0) && (spike_cnt_q == max_q)) ||
                    (dark ? (emit_pix > thresh_q) : (emit_pix < thresh_q));

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    thresh_d     = thresh_q;
    max_d        = max_q;
    pix_cnt_d    = pix_cnt_q;
    bin_d        = bin_q;
    sort_i_d     = sort_i_q;
    word_cnt_d   = word_cnt_q;
    spike_cnt_d  = spike_cnt_q;
    abort_pend_d = abort_pend_q;
    img_d        = img_q;
    sorted_d     = sorted_q;
    h_clr        = 1'b0;
    h_inc        = 1'b0;
    h_acc        = 1'b0;
    h_dec        = 1'b0;
    h_bin        = bin_q;
    found        = 1'b0;
    word         = next_index_q;

    case (state_q)
      IDLE: begin
        if (NEW_IMAGE) begin
          mode_d       = roc_mode_t'(MODE);
          thresh_d     = THRESH;
          max_d        = MAX_SPIKES;
          h_clr        = 1'b1;
          spike_cnt_d  = '0;
          pix_cnt_d    = '0;
          abort_pend_d = 1'b0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        h_bin = PIX_DATA;
        if (PIX_VALID && pix_ready_q) begin
          img_d[pix_cnt_q] = PIX_DATA;
          h_inc            = 1'b1;
          pix_cnt_d        = pix_cnt_q + ONE_IDX;
          if (pix_cnt_q == LAST_PIX) begin
            state_d = CUMSUM;
            bin_d   = dark ? ONE_BIN : (MAX_BIN - ONE_BIN);
          end
        end
      end
      CUMSUM: begin
        if (INFERENCE_RDY) begin
          state_d = IDLE;
        end else begin
          h_acc = 1'b1;
          if (dark ? (bin_q == MAX_BIN) : (bin_q == '0)) begin
            state_d  = SORT;
            sort_i_d = LAST_PIX;
          end else begin
            bin_d = dark ? (bin_q + ONE_BIN) : (bin_q - ONE_BIN);
          end
        end
      end
      SORT: begin
        h_bin = sort_pix;
        if (INFERENCE_RDY) begin
          state_d = IDLE;
        end else begin
          h_dec              = 1'b1;
          sorted_d[sort_pos] = sort_i_q;
          if (sort_i_q == '0) begin
            state_d    = PREFIX;
            word_cnt_d = '0;
          end else begin
            sort_i_d = sort_i_q - ONE_IDX;
          end
        end
      end
      PREFIX: begin
        if (INFERENCE_RDY) begin
          state_d = IDLE;
        end else if (word_cnt_q == PREFIX_LEN) begin
          state_d = EMIT;
        end else if (!AERIN_CTRL_BUSY) begin
          found      = 1'b1;
          word       = RESET_WORD;
          word_cnt_d = word_cnt_q + ONE_WORD;
          state_d    = WAIT_AER;
        end
      end
      EMIT: begin
        if (INFERENCE_RDY || emit_end) begin
          state_d = IDLE;
        end else if (!AERIN_CTRL_BUSY) begin
          found       = 1'b1;
          word        = AER_BITS'(emit_idx);
          spike_cnt_d = spike_cnt_q + ONE_CNT;
          state_d     = WAIT_AER;
        end
      end
      WAIT_AER: begin
        // An abort seen while the word is in flight waits for the handshake.
        if (INFERENCE_RDY) abort_pend_d = 1'b1;
        if (!AERIN_CTRL_BUSY) begin
          if (abort_pend_q || INFERENCE_RDY) state_d = IDLE;
          else if (word_cnt_q == PREFIX_LEN) state_d = EMIT;
          else                               state_d = PREFIX;
        end
      end
      default: state_d = IDLE;
    endcase

    next_index_d = word;
    pix_ready_d  = (state_d == LOAD);
    enc_rdy_d    = (state_d == IDLE);
    frame_done_d = (state_d == IDLE) && (state_q != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      mode_q       <= ROC_BRIGHT_FIRST;
      thresh_q     <= '0;
      max_q        <= '0;
      pix_cnt_q    <= '0;
      bin_q        <= '0;
      sort_i_q     <= '0;
      word_cnt_q   <= '0;
      spike_cnt_q  <= '0;
      abort_pend_q <= 1'b0;
      next_index_q <= '0;
      pix_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
      enc_rdy_q    <= 1'b1;
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        img_q[i]    <= '0;
        sorted_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      thresh_q     <= thresh_d;
      max_q        <= max_d;
      pix_cnt_q    <= pix_cnt_d;
      bin_q        <= bin_d;
      sort_i_q     <= sort_i_d;
      word_cnt_q   <= word_cnt_d;
      spike_cnt_q  <= spike_cnt_d;
      abort_pend_q <= abort_pend_d;
      next_index_q <= next_index_d;
      pix_ready_q  <= pix_ready_d;
      frame_done_q <= frame_done_d;
      enc_rdy_q    <= enc_rdy_d;
      img_q        <= img_d;
      sorted_q     <= sorted_d;
    end
  end

  // The strobe qualifies on the live busy input so it lands in a busy-low cycle.
  assign FOUND_NEXT_INDEX = found;
  assign NEXT_INDEX       = word;
  assign PIX_READY        = pix_ready_q;
  assign SPIKE_COUNT      = spike_cnt_q;
  assign FRAME_DONE       = frame_done_q;
  assign ENCODER_RDY      = enc_rdy_q;

endmodule

// File: tb/tb_roc_stream_encoder.sv
// Directed bench for roc_stream_encoder with a sort-by-intensity reference model.
module tb_roc_stream_encoder;

  localparam int N  = 4;
  localparam int RW = 2;
  localparam logic [9:0] RCODE = 10'h1FF;
  localparam int LATENCY = 1 + N + 255 + N;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       NEW_IMAGE, MODE, PIX_VALID, PIX_READY;
  logic [7:0] THRESH, PIX_DATA;
  logic [2:0] MAX_SPIKES, SPIKE_COUNT;
  logic       AERIN_CTRL_BUSY, INFERENCE_RDY;
  logic [9:0] NEXT_INDEX;
  logic       FOUND_NEXT_INDEX, FRAME_DONE, ENCODER_RDY;

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  roc_stream_encoder #(
    .IMAGE_SIZE(N), .PIXEL_BITS(8), .AER_BITS(10), .RESET_WORDS(RW), .RESET_CODE(32'h1FF)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .NEW_IMAGE(NEW_IMAGE), .MODE(MODE), .THRESH(THRESH),
    .MAX_SPIKES(MAX_SPIKES), .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA), .PIX_READY(PIX_READY),
    .AERIN_CTRL_BUSY(AERIN_CTRL_BUSY), .INFERENCE_RDY(INFERENCE_RDY), .NEXT_INDEX(NEXT_INDEX),
    .FOUND_NEXT_INDEX(FOUND_NEXT_INDEX), .SPIKE_COUNT(SPIKE_COUNT), .FRAME_DONE(FRAME_DONE),
    .ENCODER_RDY(ENCODER_RDY)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Reference: walk intensities in emission order, pixels in index order.
  logic [7:0] img_cfg [N];
  int         model_out [N];

  function automatic int model(input bit mode, input int th, input int mx);
    int n = 0;
    int v;
    for (int s = 0; s < 256; s++) begin
      v = mode ? s : 255 - s;
      for (int i = 0; i < N; i++) begin
        if (int'(img_cfg[i]) == v && (mode ? (v <= th) : (v >= th)) && (mx == 0 || n < mx)) begin
          model_out[n] = i;
          n++;
        end
      end
    end
    return n;
  endfunction

  logic [9:0] exp_q [$];
  logic [9:0] last_word = '0;
  int         mstrobes  = 0;
  int         first_cyc = -1;
  int         abort_at  = -1;
  int         busy_len  = 2;

  // Scoreboard: every strobe must match the queue; between strobes the word holds.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        if (NEW_IMAGE) begin
          mstrobes  = 0;
          first_cyc = -1;
        end
        if (FOUND_NEXT_INDEX) begin
          check("strobe_busy_low", AERIN_CTRL_BUSY, 0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got %0h, required no strobe", NEXT_INDEX);
          end else begin
            last_word = exp_q.pop_front();
            check("next_index", NEXT_INDEX, last_word);
          end
          if (mstrobes == 0) first_cyc = cyc;
          mstrobes++;
        end else begin
          check("index_hold", NEXT_INDEX, last_word);
        end
      end
    end
  end

  // AER controller: busy for a while after each accepted word; optional abort.
  int bcount = 0;
  initial begin
    int  hold;
    bit  is_abort;
    AERIN_CTRL_BUSY = 1'b0;
    INFERENCE_RDY   = 1'b0;
    forever begin
      @(negedge CLK);
      if (NEW_IMAGE) bcount = 0;
      if (RST_N && FOUND_NEXT_INDEX) begin
        is_abort = (bcount == abort_at);
        hold     = is_abort ? 5 : busy_len;
        bcount++;
        @(posedge CLK); #1;
        AERIN_CTRL_BUSY = (hold > 0);
        for (int c = 0; c < hold; c++) begin
          INFERENCE_RDY = is_abort && (c == 1);
          @(posedge CLK); #1;
        end
        INFERENCE_RDY   = 1'b0;
        AERIN_CTRL_BUSY = 1'b0;
        if (is_abort) begin
          @(negedge CLK);
          check("abort_no_strobe", FOUND_NEXT_INDEX, 0);
          check("abort_not_idle_yet", ENCODER_RDY, 0);
          @(negedge CLK);
          check("abort_frame_done", FRAME_DONE, 1);
          check("abort_idle", ENCODER_RDY, 1);
        end
      end
    end
  end

  task automatic run_frame(input string tag, input bit mode, input int th, input int mx,
                           input bit toggle, input int abort_i, input int rst_at);
    int  n, exp_idx, beat, tries, start;
    bit  rdy, done, was_reset;
    n = model(mode, th, mx);
    exp_q.delete();
    for (int i = 0; i < RW; i++) exp_q.push_back(RCODE);
    for (int i = 0; i < n; i++) exp_q.push_back(10'(model_out[i]));
    exp_idx = n;
    if (abort_i >= 0) begin
      while (exp_q.size() > abort_i + 1) void'(exp_q.pop_back());
      exp_idx = abort_i + 1 - RW;
    end
    abort_at = abort_i;

    for (int k = 0; k < 50 && !ENCODER_RDY; k++) @(negedge CLK);
    check({tag, "_ready_before_start"}, ENCODER_RDY, 1);
    @(posedge CLK); #1;
    NEW_IMAGE  = 1'b1;
    MODE       = mode;
    THRESH     = 8'(th);
    MAX_SPIKES = 3'(mx);
    start      = cyc;
    @(posedge CLK); #1;
    // Scramble the configuration inputs: the encoder must use the latched values.
    NEW_IMAGE  = 1'b0;
    MODE       = ~mode;
    THRESH     = ~8'(th);
    MAX_SPIKES = 3'd5;

    beat  = 0;
    tries = 0;
    while (beat < N && tries < 40) begin
      PIX_VALID = toggle ? ((tries % 2) == 0) : 1'b1;
      PIX_DATA  = img_cfg[beat];
      @(negedge CLK);
      rdy = PIX_READY;
      if (toggle && !PIX_VALID) check({tag, "_ready_in_gap"}, PIX_READY, 1);
      @(posedge CLK); #1;
      if (rdy && PIX_VALID) beat++;
      tries++;
    end
    check({tag, "_beats_accepted"}, beat, N);
    PIX_VALID = 1'b1;
    PIX_DATA  = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check({tag, "_ready_after_load"}, PIX_READY, 0);
    end
    @(posedge CLK); #1;
    PIX_VALID = 1'b0;

    done      = 1'b0;
    was_reset = 1'b0;
    for (int k = 0; k < 1500 && !done && !was_reset; k++) begin
      @(negedge CLK); #1;
      if (FRAME_DONE) done = 1'b1;
      else if (rst_at >= 0 && mstrobes > rst_at) begin
        #1 RST_N = 1'b0;
        #1;
        check({tag, "_rst_found"}, FOUND_NEXT_INDEX, 0);
        check({tag, "_rst_index"}, NEXT_INDEX, 0);
        check({tag, "_rst_count"}, SPIKE_COUNT, 0);
        check({tag, "_rst_ready"}, PIX_READY, 0);
        check({tag, "_rst_done"}, FRAME_DONE, 0);
        check({tag, "_rst_enc_rdy"}, ENCODER_RDY, 1);
        exp_q.delete();
        last_word = '0;
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        check({tag, "_post_rst_idle"}, ENCODER_RDY, 1);
        check({tag, "_post_rst_no_done"}, FRAME_DONE, 0);
        was_reset = 1'b1;
      end
    end
    if (!was_reset) begin
      if (!done) fail_now({tag, "_frame_done_timeout"});
      check({tag, "_all_words_sent"}, exp_q.size(), 0);
      check({tag, "_spike_count"}, SPIKE_COUNT, exp_idx);
      if (!toggle && abort_i < 0) check({tag, "_latency"}, first_cyc - start, LATENCY);
      @(negedge CLK);
      check({tag, "_done_one_cycle"}, FRAME_DONE, 0);
      check({tag, "_idle_after"}, ENCODER_RDY, 1);
    end
    abort_at = -1;
  endtask

  initial begin
    int n;
    RST_N = 1'b0; NEW_IMAGE = 1'b0; MODE = 1'b0; THRESH = '0; MAX_SPIKES = '0;
    PIX_VALID = 1'b0; PIX_DATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_enc_rdy", ENCODER_RDY, 1);
    check("reset_pix_ready", PIX_READY, 0);
    check("reset_found", FOUND_NEXT_INDEX, 0);
    check("reset_frame_done", FRAME_DONE, 0);
    check("reset_next_index", NEXT_INDEX, 0);
    check("reset_spike_count", SPIKE_COUNT, 0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_no_done", FRAME_DONE, 0);

    // Pin the reference model against hand-sorted orders.
    img_cfg = '{8'd10, 8'd200, 8'd10, 8'd50};
    n = model(1'b0, 0, 0);
    check("model_bright_n", n, 4);
    check("model_bright_seq", {model_out[0][7:0], model_out[1][7:0], model_out[2][7:0],
                               model_out[3][7:0]}, 32'h01_03_00_02);
    n = model(1'b1, 255, 0);
    check("model_dark_seq", {model_out[0][7:0], model_out[1][7:0], model_out[2][7:0],
                             model_out[3][7:0]}, 32'h00_02_03_01);
    n = model(1'b0, 20, 0);
    check("model_thresh_n", n, 2);
    n = model(1'b0, 20, 1);
    check("model_cap_n", n, 1);
    check("model_cap_idx", model_out[0], 1);

    run_frame("bright", 1'b0, 0, 0, 1'b0, -1, -1);
    run_frame("dark", 1'b1, 255, 0, 1'b0, -1, -1);
    run_frame("thresh", 1'b0, 20, 0, 1'b0, -1, -1);
    run_frame("cap", 1'b0, 20, 1, 1'b0, -1, -1);

    img_cfg = '{8'd7, 8'd7, 8'd7, 8'd7};
    n = model(1'b0, 7, 0);
    check("model_uniform_seq", {model_out[0][7:0], model_out[1][7:0], model_out[2][7:0],
                                model_out[3][7:0]}, 32'h00_01_02_03);
    run_frame("uniform", 1'b0, 7, 0, 1'b1, -1, -1);

    img_cfg = '{8'd10, 8'd200, 8'd10, 8'd50};
    run_frame("abort", 1'b0, 0, 0, 1'b0, 2, -1);
    run_frame("reset_mid", 1'b0, 0, 0, 1'b0, -1, 4);
    repeat (4) @(negedge CLK);
    run_frame("after_reset", 1'b0, 0, 0, 1'b0, -1, -1);

    repeat (5) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
